maze_env: RTL

- Synthesizable maze/world model that closes the loop around the robot controllers (mealy/moore).
- Consumes the robot's commands f (forward) and r (rotate) and produces the sensor inputs h (wall ahead) and l (wall on left).
- Replaces file-driven sensor stimulus, so a controller can run free against a parameterized map. Tracks position, heading, move count and goal arrival.

---
 rtl/maze_env.sv | 125 ++++++++++++
 1 files changed

// File: rtl/maze_env.sv
// Grid-world model closing the loop around a robot controller: turns f/r commands into
// h/l wall sensors while tracking position, heading, accepted moves and goal arrival.
module maze_env #(
    parameter int unsigned MAP_W = 8,
    parameter int unsigned MAP_H = 8,
    parameter logic [MAP_W*MAP_H-1:0] MAP_BITS = '0,
    parameter int unsigned START_X = 0,
    parameter int unsigned START_Y = 0,
    parameter logic [1:0] START_DIR = 2'd0,
    parameter int unsigned GOAL_X = MAP_W - 1,
    parameter int unsigned GOAL_Y = MAP_H - 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    input  logic        f,
    input  logic        r,
    output logic        h,
    output logic        l,
    output logic [3:0]  pos_x,
    output logic [3:0]  pos_y,
    output logic [1:0]  dir,
    output logic        bump,
    output logic        cmd_err,
    output logic        done,
    output logic [15:0] moves
);

    localparam logic START_DONE = (START_X == GOAL_X) && (START_Y == GOAL_Y);

    if (MAP_BITS[START_Y*MAP_W+START_X]) begin : g_bad_start
        $error("maze_env: start cell (%0d,%0d) is a wall", START_X, START_Y);
    end

    // Signed 6-bit coordinates so stepping off either edge goes out of range, never wraps.
    function automatic logic signed [5:0] off_x(input logic [1:0] d);
        return (d == 2'd1) ? 6'sd1 : (d == 2'd3) ? -6'sd1 : 6'sd0;
    endfunction

    function automatic logic signed [5:0] off_y(input logic [1:0] d);
        return (d == 2'd0) ? -6'sd1 : (d == 2'd2) ? 6'sd1 : 6'sd0;
    endfunction

    function automatic logic cell_blocked(input logic signed [5:0] x,
                                          input logic signed [5:0] y);
        logic [7:0] idx;
        if (x < 6'sd0 || y < 6'sd0 || x >= $signed(6'(MAP_W)) || y >= $signed(6'(MAP_H))) begin
            return 1'b1;
        end
        idx = 8'(y[3:0]) * 8'(MAP_W) + 8'(x[3:0]);
        return MAP_BITS[idx];
    endfunction

    logic [3:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [1:0]  dir_q, dir_d, left_dir;
    logic        bump_q, bump_d, cmd_err_q, cmd_err_d, done_q, done_d;
    logic [15:0] moves_q, moves_d;
    logic signed [5:0] ahead_x, ahead_y, left_x, left_y;

    always_comb begin
        left_dir = dir_q + 2'd3;
        ahead_x  = $signed({2'b00, pos_x_q}) + off_x(dir_q);
        ahead_y  = $signed({2'b00, pos_y_q}) + off_y(dir_q);
        left_x   = $signed({2'b00, pos_x_q}) + off_x(left_dir);
        left_y   = $signed({2'b00, pos_y_q}) + off_y(left_dir);
        h        = cell_blocked(ahead_x, ahead_y);
        l        = cell_blocked(left_x, left_y);
    end

    always_comb begin
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        dir_d     = dir_q;
        moves_d   = moves_q;
        done_d    = done_q;
        bump_d    = 1'b0;
        cmd_err_d = 1'b0;
        if (step && !done_q) begin
            if (r) begin
                dir_d     = dir_q + 2'd1;
                cmd_err_d = f;
            end else if (f) begin
                if (h) begin
                    bump_d = 1'b1;
                end else begin
                    pos_x_d = ahead_x[3:0];
                    pos_y_d = ahead_y[3:0];
                    if (moves_q != 16'hFFFF) moves_d = moves_q + 16'd1;
                    if (ahead_x == $signed(6'(GOAL_X)) && ahead_y == $signed(6'(GOAL_Y))) begin
                        done_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x_q   <= 4'(START_X);
            pos_y_q   <= 4'(START_Y);
            dir_q     <= START_DIR;
            bump_q    <= 1'b0;
            cmd_err_q <= 1'b0;
            done_q    <= START_DONE;
            moves_q   <= 16'd0;
        end else begin
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            dir_q     <= dir_d;
            bump_q    <= bump_d;
            cmd_err_q <= cmd_err_d;
            done_q    <= done_d;
            moves_q   <= moves_d;
        end
    end

    assign pos_x   = pos_x_q;
    assign pos_y   = pos_y_q;
    assign dir     = dir_q;
    assign bump    = bump_q;
    assign cmd_err = cmd_err_q;
    assign done    = done_q;
    assign moves   = moves_q;

endmodule
